// File: rtl/wash_scheduler.sv
// Round-robin front end sharing one washing-machine core among N_REQ request slots.
// Optional hung-core watchdog enabled by defining WASH_SCHED_WATCHDOG_EN.
module wash_scheduler #(
   parameter int N_REQ       = 4,
   parameter int ID_W        = 2,
   parameter int WDOG_CYCLES = 64
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N_REQ-1:0] req,
   input  logic [N_REQ-1:0] req_dbl,
   input  logic [N_REQ-1:0] req_dry,
   input  logic             pause_req,
   input  logic             fault_clr,
   input  logic             mc_done,
   output logic [N_REQ-1:0] ack,
   output logic [N_REQ-1:0] cycle_done,
   output logic             busy,
   output logic [ID_W-1:0]  owner,
   output logic             mc_start,
   output logic             mc_double_wash,
   output logic             mc_dry_wash,
   output logic             mc_time_pause,
   output logic             fault
);

   typedef enum logic [1:0] {IDLE, LAUNCH, RUN, FAULT} state_t;

   state_t          state;
   logic [ID_W-1:0] rr;
   logic [ID_W-1:0] winner;
   logic            found;
   logic            seen_low;
   logic            done_now;

   function automatic logic [ID_W-1:0] next_slot(input logic [ID_W-1:0] s);
      return (s == ID_W'(N_REQ - 1)) ? '0 : s + ID_W'(1);
   endfunction

   // NOTE: every variable written here gets a default first, so no latch is inferred.
   always_comb begin
      found  = 1'b0;
      winner = '0;
      for (int i = 0; i < N_REQ; i++) begin
         automatic int idx = (int'(rr) + i) % N_REQ;
         if (!found && req[idx]) begin
            found  = 1'b1;
            winner = ID_W'(idx);
         end
      end
   end

   // A done level only counts once the core has been seen low in this run.
   assign done_now      = (state == RUN) && mc_done && seen_low;
   assign busy          = (state == LAUNCH) || (state == RUN);
   assign mc_time_pause = pause_req && (state == RUN);

`ifdef WASH_SCHED_WATCHDOG_EN
   localparam int CNT_W = $clog2(WDOG_CYCLES + 1);
   logic [CNT_W-1:0] wdog_cnt;
   logic             wdog_fire;

   assign wdog_fire = (state == RUN) && !mc_time_pause && !done_now &&
                      (wdog_cnt == CNT_W'(WDOG_CYCLES - 1));
`else
   logic unused_cfg;
   assign unused_cfg = fault_clr ^ (WDOG_CYCLES > 0);
   assign fault      = 1'b0;
`endif

   // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state          <= IDLE;
         rr             <= '0;
         owner          <= '0;
         ack            <= '0;
         cycle_done     <= '0;
         mc_start       <= 1'b0;
         mc_double_wash <= 1'b0;
         mc_dry_wash    <= 1'b0;
         seen_low       <= 1'b0;
`ifdef WASH_SCHED_WATCHDOG_EN
         fault          <= 1'b0;
         wdog_cnt       <= '0;
`endif
      end else begin
         ack        <= '0;
         cycle_done <= '0;
         mc_start   <= 1'b0;
         case (state)
            IDLE: begin
               if (found) begin
                  owner          <= winner;
                  ack[winner]    <= 1'b1;
                  mc_dry_wash    <= req_dry[winner];
                  mc_double_wash <= req_dbl[winner] & ~req_dry[winner];
                  state          <= LAUNCH;
               end
            end
            LAUNCH: begin
               mc_start <= 1'b1;
               seen_low <= 1'b0;
               state    <= RUN;
            end
            RUN: begin
               if (!mc_done) seen_low <= 1'b1;
               if (done_now) begin
                  cycle_done[owner] <= 1'b1;
                  rr                <= next_slot(owner);
                  mc_dry_wash       <= 1'b0;
                  mc_double_wash    <= 1'b0;
                  state             <= IDLE;
               end
`ifdef WASH_SCHED_WATCHDOG_EN
               else if (wdog_fire) begin
                  fault          <= 1'b1;
                  mc_dry_wash    <= 1'b0;
                  mc_double_wash <= 1'b0;
                  state          <= FAULT;
               end
`endif
            end
            FAULT: begin
`ifdef WASH_SCHED_WATCHDOG_EN
               if (fault_clr) begin
                  fault <= 1'b0;
                  rr    <= next_slot(owner);
                  state <= IDLE;
               end
`else
               state <= IDLE;
`endif
            end
            default: state <= IDLE;
         endcase
`ifdef WASH_SCHED_WATCHDOG_EN
         if (state == IDLE && found)
            wdog_cnt <= '0;
         else if (state == RUN && !mc_time_pause)
            wdog_cnt <= wdog_cnt + CNT_W'(1);
`endif
      end
   end

endmodule
